// File: rtl/ibus_responder.sv
// Instruction-pair fetch responder: turns one 64-bit fetch request into two
// sequential single-word memory reads and returns both words together.
module ibus_responder (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [63:0] iresp_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] base_addr;
  logic [31:0] aligned_addr;

  assign aligned_addr  = {ireq_addr[31:2], 2'b00};
  assign iresp_addr_ok = (state == IDLE) && ireq_valid;

  // mem_req is asserted on entry to REQ0/REQ1 so it is registered yet aligned with the state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      base_addr     <= 32'h0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= 64'h0;
      mem_req       <= 1'b0;
      mem_addr      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (ireq_valid) begin
            base_addr <= aligned_addr;
            mem_addr  <= aligned_addr;
            mem_req   <= 1'b1;
            state     <= REQ0;
          end
        end
        REQ0: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            iresp_data[31:0] <= mem_rdata;
            mem_addr         <= base_addr + 32'd4;  // wraps naturally at 2^32
            mem_req          <= 1'b1;
            state            <= REQ1;
          end
        end
        REQ1: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            iresp_data[63:32] <= mem_rdata;
            iresp_data_ok     <= 1'b1;
            state             <= RESP;
          end
        end
        RESP: begin
          iresp_data_ok <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          iresp_data_ok <= 1'b0;
          mem_req       <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed self-checking bench for ibus_responder: zero-wait, stalls,
// back-to-back, address wrap, spurious rvalid and mid-transaction reset.
module tb_ibus_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [63:0] iresp_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ibus_responder dut (
    .clk          (clk),
    .resetn       (resetn),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full fetch cycle by cycle. Starts just after a rising edge with
  // the DUT in IDLE; returns just after the edge that ends the RESP cycle.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                          input int rs0, input int vs0, input int rs1, input int vs1,
                          input bit hold, input logic [31:0] next_addr, input bit spur,
                          input int exp_lat);
    logic [31:0] base;
    logic [31:0] base4;
    int n;
    base  = {addr[31:2], 2'b00};
    base4 = base + 32'd4;
    n     = 0;
    ireq_valid = 1'b1;
    ireq_addr  = addr;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check_val("addr_ok_accept", iresp_addr_ok, 1);
    check_val("mem_req_idle", mem_req, 0);
    tick(); n++;
    ireq_valid = hold;
    ireq_addr  = hold ? next_addr : 32'h0;
    for (int k = 0; k <= rs0; k++) begin
      mem_ready  = (k == rs0);
      mem_rvalid = spur;
      mem_rdata  = 32'hDEADBEEF;
      #1;
      check_val("req0_mem_req", mem_req, 1);
      check_val("req0_mem_addr", mem_addr, base);
      check_val("req0_addr_ok", iresp_addr_ok, 0);
      tick(); n++;
    end
    mem_ready = 1'b0;
    for (int k = 0; k <= vs0; k++) begin
      mem_rvalid = (k == vs0);
      mem_rdata  = (k == vs0) ? d0 : 32'hDEADBEEF;
      #1;
      check_val("wait0_mem_req", mem_req, 0);
      check_val("wait0_data_ok", iresp_data_ok, 0);
      check_val("wait0_addr_ok", iresp_addr_ok, 0);
      tick(); n++;
    end
    for (int k = 0; k <= rs1; k++) begin
      mem_ready  = (k == rs1);
      mem_rvalid = spur;
      mem_rdata  = 32'hDEADBEEF;
      #1;
      check_val("req1_mem_req", mem_req, 1);
      check_val("req1_mem_addr", mem_addr, base4);
      check_val("req1_addr_ok", iresp_addr_ok, 0);
      tick(); n++;
    end
    mem_ready = 1'b0;
    for (int k = 0; k <= vs1; k++) begin
      mem_rvalid = (k == vs1);
      mem_rdata  = (k == vs1) ? d1 : 32'hDEADBEEF;
      #1;
      check_val("wait1_mem_req", mem_req, 0);
      check_val("wait1_data_ok", iresp_data_ok, 0);
      check_val("wait1_addr_ok", iresp_addr_ok, 0);
      tick(); n++;
    end
    mem_rvalid = spur;
    mem_rdata  = 32'hDEADBEEF;
    #1;
    check_val("resp_data_ok", iresp_data_ok, 1);
    check_val("resp_data", iresp_data, {d1, d0});
    check_val("resp_mem_req", mem_req, 0);
    check_val("resp_addr_ok", iresp_addr_ok, 0);
    check_val("resp_latency", n, exp_lat);
    tick();
    mem_rvalid = 1'b0;
    check_val("post_data_ok", iresp_data_ok, 0);
    check_val("post_data_hold", iresp_data, {d1, d0});
    check_val("post_mem_req", mem_req, 0);
    $display("read addr=%h data=%h latency=%0d", addr, {d1, d0}, n);
  endtask

  initial begin
    resetn     = 1'b0;
    ireq_valid = 1'b0;
    ireq_addr  = 32'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    check_val("rst_data_ok", iresp_data_ok, 0);
    check_val("rst_data", iresp_data, 0);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_addr_ok", iresp_addr_ok, 0);
    resetn = 1'b1;
    tick();

    // zero-wait read
    run_read(32'hBFC00000, 32'h11111111, 32'h22222222, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 5);

    // spurious rvalid in IDLE
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    #1;
    check_val("spur_addr_ok", iresp_addr_ok, 0);
    tick();
    mem_rvalid = 1'b0;
    check_val("spur_data_ok", iresp_data_ok, 0);
    check_val("spur_data", iresp_data, 64'h22222222_11111111);
    check_val("spur_mem_req", mem_req, 0);
    $display("spurious rvalid in idle data=%h", iresp_data);

    // stalls: 3 cycles on ready in REQ0, 4 extra cycles on rvalid in WAIT1, junk rvalid in REQ states
    run_read(32'hBFC00000, 32'hAAAA5555, 32'h0F0F0F0F, 3, 0, 0, 4, 1'b0, 32'h0, 1'b1, 12);

    // back-to-back with ireq_valid held high
    run_read(32'h00000100, 32'h01234567, 32'h89ABCDEF, 0, 0, 0, 0, 1'b1, 32'h00000108, 1'b0, 5);
    run_read(32'h00000108, 32'h76543210, 32'hFEDCBA98, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 5);

    // misaligned address at the top of the map wraps to zero
    run_read(32'hFFFFFFFE, 32'hCAFEF00D, 32'h55AA55AA, 0, 1, 1, 0, 1'b0, 32'h0, 1'b0, 7);

    // reset while in WAIT1, then late rvalid pulses
    ireq_valid = 1'b1;
    ireq_addr  = 32'h00002000;
    #1;
    check_val("rw_accept", iresp_addr_ok, 1);
    tick();
    ireq_valid = 1'b0;
    mem_ready  = 1'b1;
    #1;
    check_val("rw_req0_addr", mem_addr, 32'h00002000);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    #1;
    check_val("rw_req1_addr", mem_addr, 32'h00002004);
    tick();
    mem_ready = 1'b0;
    resetn    = 1'b0;
    tick();
    resetn     = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h88888888;
    #1;
    check_val("rw_data_cleared", iresp_data, 0);
    check_val("rw_data_ok", iresp_data_ok, 0);
    check_val("rw_mem_req", mem_req, 0);
    check_val("rw_mem_addr", mem_addr, 0);
    check_val("rw_addr_ok", iresp_addr_ok, 0);
    tick();
    check_val("rw_late1_data_ok", iresp_data_ok, 0);
    check_val("rw_late1_data", iresp_data, 0);
    tick();
    mem_rvalid = 1'b0;
    check_val("rw_late2_data_ok", iresp_data_ok, 0);
    check_val("rw_late2_data", iresp_data, 0);
    $display("reset in wait1 data=%h data_ok=%0b", iresp_data, iresp_data_ok);

    run_read(32'h00003000, 32'h13579BDF, 32'h2468ACE0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibus_responder.md
IBUS_RESPONDER -- requirements
Module: ibus_responder

Interface
REQ-001 No parameters; all widths fixed as listed below.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 ireq_valid  input  1  fetch stage requests an instruction pair.
REQ-005 ireq_addr  input  32  byte address of the first instruction of the pair.
REQ-006 iresp_addr_ok  output  1  request accepted this cycle.
REQ-007 iresp_data_ok  output  1  iresp_data valid this cycle.
REQ-008 iresp_data  output  64  [31:0] = word at the accepted address; [63:32] = word at accepted address + 4.
REQ-009 mem_req  output  1  single-word read request to memory.
REQ-010 mem_addr  output  32  word-aligned memory read address.
REQ-011 mem_ready  input  1  memory accepts mem_req this cycle.
REQ-012 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-013 mem_rdata  input  32  read data.

Function
REQ-014 The FSM SHALL have exactly six states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-015 iresp_addr_ok SHALL be combinational: 1 iff state==IDLE and ireq_valid==1.
REQ-016 On acceptance, the block SHALL latch {ireq_addr[31:2],2'b00} as the base address and move to REQ0.
REQ-017 ireq_addr bits [1:0] SHALL be ignored.
REQ-018 ireq_valid and ireq_addr SHALL have no effect outside IDLE; there is one outstanding request at most.
REQ-019 In REQ0, mem_req=1 and mem_addr=base; on mem_ready=1 the FSM SHALL move to WAIT0; otherwise it holds with mem_addr stable.
REQ-020 In WAIT0, on mem_rvalid=1 the block SHALL capture mem_rdata into iresp_data[31:0] and move to REQ1.
REQ-021 In REQ1, mem_req=1 and mem_addr=base+4, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); on mem_ready=1 the FSM SHALL move to WAIT1.
REQ-022 In WAIT1, on mem_rvalid=1 the block SHALL capture mem_rdata into iresp_data[63:32] and move to RESP.
REQ-023 mem_req SHALL be 0 in IDLE, WAIT0, WAIT1 and RESP.
REQ-024 mem_addr SHALL hold its last value when mem_req=0.
REQ-025 mem_rvalid SHALL be ignored in IDLE, REQ0, REQ1 and RESP, and SHALL NOT alter iresp_data in those states.
REQ-026 Memory contract: mem_rvalid never arrives earlier than the cycle after the mem_req&mem_ready handshake.
REQ-027 In RESP, iresp_data_ok=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 iresp_data_ok SHALL be 0 in every state other than RESP.
REQ-029 iresp_data SHALL hold its value after RESP until overwritten by the next request's WAIT0/WAIT1 captures.
REQ-030 A request presented in the cycle after RESP (state IDLE) SHALL be accepted that cycle.
REQ-031 Latency with mem_ready=1 and mem_rvalid one cycle after each handshake: acceptance in cycle N, iresp_data_ok in cycle N+5.
REQ-032 Accepted requests SHALL NOT be cancelable; consumers discard unwanted responses.
REQ-033 Arbitrary stall lengths on mem_ready or mem_rvalid SHALL only extend the wait and SHALL NOT lose data.

Reset
REQ-034 With resetn=0 at a clock edge, state SHALL become IDLE.
REQ-035 Reset values of all registered outputs: iresp_data_ok=0, iresp_data=0, mem_req=0, mem_addr=0.
REQ-036 iresp_addr_ok SHALL follow REQ-015 once state is IDLE.
REQ-037 Reset mid-transaction SHALL abandon the request; a late mem_rvalid after reset SHALL be ignored and SHALL produce no iresp_data_ok.

Verification
REQ-038 Zero-wait read: ireq_addr=0xBFC00000 accepted in cycle 0; memory returns 0x11111111 then 0x22222222 -> mem_addr 0xBFC00000 then 0xBFC00004; iresp_data_ok=1 only in cycle 5 with iresp_data=0x22222222_11111111.
REQ-039 Stalls: mem_ready held low 3 cycles in REQ0 and mem_rvalid delayed 4 cycles in WAIT1 -> mem_req/mem_addr stable throughout; correct data; data_ok 7 cycles later than REQ-038.
REQ-040 Back-to-back: ireq_valid held high with addresses 0x100 then 0x108 -> second addr_ok in the cycle after the first data_ok; no overlap of mem_req between requests.
REQ-041 Wrap and misalignment: ireq_addr=0xFFFFFFFE -> mem_addr 0xFFFFFFFC then 0x00000000.
REQ-042 Spurious input: mem_rvalid=1 with 0xDEADBEEF while in IDLE -> iresp_data unchanged, no data_ok.
REQ-043 Reset in WAIT1, then mem_rvalid pulses -> state IDLE, iresp_data=0, no data_ok, next request serviced normally.
